// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-lite register responder: response codes,
// channel FSM state encodings and the address-to-register decode.
package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic [15:0] idx;
        logic        in_range;
    } addr_dec_t;

    // Byte-offset bits are dropped; any set bit above the index field is out of range.
    function automatic addr_dec_t decode_addr(input logic [63:0] addr,
                                              input int unsigned n_bytes,
                                              input int unsigned reg_count);
        addr_dec_t   dec;
        int unsigned lsb_w;
        int unsigned idx_w;
        lsb_w        = $clog2(n_bytes);
        idx_w        = $clog2(reg_count);
        dec.idx      = 16'((addr >> lsb_w) & (64'(reg_count) - 64'd1));
        dec.in_range = ((addr >> (lsb_w + idx_w)) == 64'd0);
        return dec;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-lite responder terminating one link into REG_COUNT read/write registers.
// Define AXI4_LITE_REG_SLAVE_PROT_CHECK_EN to reject unprivileged (prot[0]=0) accesses.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int A         = 32,
    parameter int N         = 4,
    parameter int REG_COUNT = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [A-1:0]               awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [8*N-1:0]             wdata,
    input  logic [N-1:0]               wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [A-1:0]               araddr,
    input  logic [2:0]                 arprot,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [8*N-1:0]             rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [REG_COUNT*8*N-1:0]   regs,
    output logic [REG_COUNT-1:0]       wr_pulse
);

    localparam int DW    = 8 * N;
    localparam int IDX_W = $clog2(REG_COUNT);

    wr_state_t          wr_state_r;
    logic               aw_done_r;
    logic               w_done_r;
    logic [A-1:0]       awaddr_r;
    logic [2:0]         awprot_r;
    logic [DW-1:0]      wdata_r;
    logic [N-1:0]       wstrb_r;

    rd_state_t          rd_state_r;

    logic               aw_hs_s;
    logic               w_hs_s;
    logic               have_aw_s;
    logic               have_w_s;
    logic [A-1:0]       eff_addr_s;
    logic [2:0]         eff_prot_s;
    logic [DW-1:0]      eff_data_s;
    logic [N-1:0]       eff_strb_s;
    addr_dec_t          wr_dec_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               wr_ok_s;

    addr_dec_t          rd_dec_s;
    logic [IDX_W-1:0]   rd_idx_s;
    logic               rd_ok_s;
    logic [DW-1:0]      rd_word_s;

    logic               unused_s;

    // Write-side decode: a handshake in this cycle supplies its live values directly.
    always_comb begin
        aw_hs_s   = awvalid & awready;
        w_hs_s    = wvalid & wready;
        have_aw_s = aw_done_r | aw_hs_s;
        have_w_s  = w_done_r | w_hs_s;
        if (aw_hs_s) begin
            eff_addr_s = awaddr;
            eff_prot_s = awprot;
        end else begin
            eff_addr_s = awaddr_r;
            eff_prot_s = awprot_r;
        end
        if (w_hs_s) begin
            eff_data_s = wdata;
            eff_strb_s = wstrb;
        end else begin
            eff_data_s = wdata_r;
            eff_strb_s = wstrb_r;
        end
        wr_dec_s = decode_addr(64'(eff_addr_s), N, REG_COUNT);
        wr_idx_s = wr_dec_s.idx[IDX_W-1:0];
`ifdef AXI4_LITE_REG_SLAVE_PROT_CHECK_EN
        wr_ok_s  = wr_dec_s.in_range & eff_prot_s[0];
`else
        wr_ok_s  = wr_dec_s.in_range;
`endif
    end

    // Read-side decode and register lookup.
    always_comb begin
        rd_dec_s  = decode_addr(64'(araddr), N, REG_COUNT);
        rd_idx_s  = rd_dec_s.idx[IDX_W-1:0];
`ifdef AXI4_LITE_REG_SLAVE_PROT_CHECK_EN
        rd_ok_s   = rd_dec_s.in_range & arprot[0];
`else
        rd_ok_s   = rd_dec_s.in_range;
`endif
        rd_word_s = regs[int'(rd_idx_s)*DW +: DW];
    end

    assign unused_s = ^{eff_prot_s, arprot, wr_dec_s.idx, rd_dec_s.idx};

    // Write channel FSM together with the register bank it updates.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_r <= W_IDLE;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            awaddr_r   <= {A{1'b0}};
            awprot_r   <= 3'b000;
            wdata_r    <= {DW{1'b0}};
            wstrb_r    <= {N{1'b0}};
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= OKAY;
            wr_pulse   <= {REG_COUNT{1'b0}};
            regs       <= {(REG_COUNT*DW){1'b0}};
        end else begin
            wr_pulse <= {REG_COUNT{1'b0}};
            case (wr_state_r)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        awaddr_r  <= awaddr;
                        awprot_r  <= awprot;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wdata_r  <= wdata;
                        wstrb_r  <= wstrb;
                        w_done_r <= 1'b1;
                    end
                    if (have_aw_s && have_w_s) begin
                        wr_state_r <= W_RESP;
                        awready    <= 1'b0;
                        wready     <= 1'b0;
                        bvalid     <= 1'b1;
                        bresp      <= wr_ok_s ? OKAY : SLVERR;
                        if (wr_ok_s) begin
                            for (int b = 0; b < N; b++) begin
                                if (eff_strb_s[b]) begin
                                    regs[int'(wr_idx_s)*DW + b*8 +: 8] <= eff_data_s[b*8 +: 8];
                                end
                            end
                            wr_pulse[wr_idx_s] <= 1'b1;
                        end
                    end else begin
                        awready <= ~have_aw_s;
                        wready  <= ~have_w_s;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wr_state_r <= W_IDLE;
                        aw_done_r  <= 1'b0;
                        w_done_r   <= 1'b0;
                        bvalid     <= 1'b0;
                        awready    <= 1'b1;
                        wready     <= 1'b1;
                    end else begin
                        bvalid     <= 1'b1;
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    aw_done_r  <= 1'b0;
                    w_done_r   <= 1'b0;
                    bvalid     <= 1'b0;
                    awready    <= 1'b0;
                    wready     <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM; data is latched at the AR handshake so a later write cannot disturb it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_r <= R_IDLE;
            arready    <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= {DW{1'b0}};
            rresp      <= OKAY;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rd_state_r <= R_DATA;
                        arready    <= 1'b0;
                        rvalid     <= 1'b1;
                        rresp      <= rd_ok_s ? OKAY : SLVERR;
                        rdata      <= rd_ok_s ? rd_word_s : {DW{1'b0}};
                    end else begin
                        arready    <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rd_state_r <= R_IDLE;
                        rvalid     <= 1'b0;
                        arready    <= 1'b1;
                    end else begin
                        rvalid     <= 1'b1;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    rvalid     <= 1'b0;
                    arready    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Scoreboard bench for axi4_lite_reg_slave: expected B/R responses are queued at issue
// time and a monitor compares them at each handshake; direct checks cover timing and regs.
module tb_axi4_lite_reg_slave;

    localparam int A  = 32;
    localparam int N  = 4;
    localparam int RC = 16;
    localparam int DW = 8 * N;

    logic            aclk;
    logic            aresetn;
    logic [A-1:0]    awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [N-1:0]    wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [A-1:0]    araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic [RC*DW-1:0] regs;
    logic [RC-1:0]   wr_pulse;

    axi4_lite_reg_slave #(.A(A), .N(N), .REG_COUNT(RC)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs(regs), .wr_pulse(wr_pulse)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rexp_t;

    logic [1:0] exp_b[$];
    rexp_t      exp_r[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [RC*DW-1:0] snap;
    logic [1:0]  prot_resp;
    logic [31:0] prot_val;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_word(input int k);
        return regs[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Monitor: compare every B and R handshake against the head of its queue
    always @(negedge aclk) begin
        if (aresetn && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected", 64'(bresp), 64'hDEAD);
            end else begin
                check("bresp", 64'(bresp), 64'(exp_b.pop_front()));
            end
        end
        if (aresetn && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                check("r_unexpected", 64'(rdata), 64'hDEAD);
            end else begin
                rexp_t e;
                e = exp_r.pop_front();
                check("rdata", 64'(rdata), 64'(e.data));
                check("rresp", 64'(rresp), 64'(e.resp));
            end
        end
    end

    task automatic write_both(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [2:0] prot);
        int n;
        awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        if (!(awready && wready)) check("aw_w_timeout", 64'(0), 64'(1));
        else tick();
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic b_handshake();
        int n;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        if (!bvalid) check("b_timeout", 64'(0), 64'(1));
        else tick();
        bready = 1'b0;
    endtask

    task automatic read_issue(input logic [31:0] addr, input logic [2:0] prot,
                              input logic [31:0] edata, input logic [1:0] eresp);
        int n;
        rexp_t e;
        e.data = edata; e.resp = eresp;
        exp_r.push_back(e);
        araddr = addr; arprot = prot; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        if (!arready) check("ar_timeout", 64'(0), 64'(1));
        else tick();
        arvalid = 1'b0;
        check("r_latency", 64'(rvalid), 64'(1));
    endtask

    task automatic r_handshake();
        int n;
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        if (!rvalid) check("r_timeout", 64'(0), 64'(1));
        else tick();
        rready = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = 32'h0; awprot = 3'b001; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 32'h0; arprot = 3'b001; arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();
        check("rst_ready", 64'({awready, wready, arready}), 64'(0));
        check("rst_valid", 64'({bvalid, rvalid}), 64'(0));
        check("rst_regs", 64'(regs == '0), 64'(1));
        check("rst_out", 64'({bresp, rresp, rdata, wr_pulse}), 64'(0));
        aresetn = 1'b1;
        tick();
        check("post_rst_ready", 64'({awready, wready, arready}), 64'(3'b111));

        // Same-cycle AW+W full write, then read back
        exp_b.push_back(2'b00);
        write_both(32'h08, 32'hDEADBEEF, 4'hF, 3'b001);
        check("t1_b_latency", 64'(bvalid), 64'(1));
        check("t1_pulse", 64'(wr_pulse), 64'(16'h0004));
        check("t1_reg2", 64'(reg_word(2)), 64'(32'hDEADBEEF));
        b_handshake();
        check("t1_pulse_gone", 64'(wr_pulse), 64'(0));
        check("t1_b_drop", 64'(bvalid), 64'(0));
        read_issue(32'h08, 3'b001, 32'hDEADBEEF, 2'b00);
        r_handshake();

        // W leads AW by 3 cycles, partial strobes over 0xFFFFFFFF
        exp_b.push_back(2'b00);
        write_both(32'h04, 32'hFFFFFFFF, 4'hF, 3'b001);
        b_handshake();
        exp_b.push_back(2'b00);
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t2_wready_low", 64'({wready, awready, bvalid}), 64'(3'b010));
        tick();
        tick();
        awaddr = 32'h04; awprot = 3'b001; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("t2_b_latency", 64'(bvalid), 64'(1));
        check("t2_reg1", 64'(reg_word(1)), 64'(32'hFF22FF44));
        b_handshake();

        // Out-of-range write and read
        snap = regs;
        exp_b.push_back(2'b10);
        write_both(32'h40, 32'h12345678, 4'hF, 3'b001);
        check("t3_no_pulse", 64'(wr_pulse), 64'(0));
        check("t3_regs_same", 64'(regs == snap), 64'(1));
        b_handshake();
        read_issue(32'h40, 3'b001, 32'h0, 2'b10);
        r_handshake();

        // bready held low: B stable, second AW blocked until after the handshake
        exp_b.push_back(2'b00);
        write_both(32'h0C, 32'h00000005, 4'hF, 3'b001);
        awaddr = 32'h10; awvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t4_hold", 64'({bvalid, bresp, awready, wready}), 64'(5'b10000));
            tick();
        end
        b_handshake();
        check("t4_aw_reopen", 64'(awready), 64'(1));
        tick();
        awvalid = 1'b0;
        check("t4_aw_taken", 64'({awready, wready, bvalid}), 64'(3'b010));
        exp_b.push_back(2'b00);
        wdata = 32'h00000077; wstrb = 4'b0001; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t4_reg4", 64'(reg_word(4)), 64'(32'h00000077));
        b_handshake();

        // Read held with rready low while a write to the same register commits
        read_issue(32'h08, 3'b001, 32'hDEADBEEF, 2'b00);
        exp_b.push_back(2'b00);
        write_both(32'h08, 32'hCAFEF00D, 4'hF, 3'b001);
        check("t5_rdata_old", 64'({rvalid, rdata}), {31'd0, 1'b1, 32'hDEADBEEF});
        b_handshake();
        r_handshake();
        read_issue(32'h08, 3'b001, 32'hCAFEF00D, 2'b00);
        r_handshake();

        // Protection bit: rejected only when the check is built in
`ifdef AXI4_LITE_REG_SLAVE_PROT_CHECK_EN
        prot_resp = 2'b10; prot_val = 32'h0;
`else
        prot_resp = 2'b00; prot_val = 32'hA5A5A5A5;
`endif
        exp_b.push_back(prot_resp);
        write_both(32'h14, 32'hA5A5A5A5, 4'hF, 3'b000);
        check("t7_prot0_reg", 64'(reg_word(5)), 64'(prot_val));
        b_handshake();
        exp_b.push_back(2'b00);
        write_both(32'h14, 32'h12345678, 4'hF, 3'b001);
        check("t7_prot1_reg", 64'(reg_word(5)), 64'(32'h12345678));
        b_handshake();
        read_issue(32'h14, 3'b000, (prot_resp == 2'b10) ? 32'h0 : 32'h12345678, prot_resp);
        r_handshake();

        // Reset while in W_RESP with reg 3 = 5
        check("t6_reg3_pre", 64'(reg_word(3)), 64'(5));
        write_both(32'h20, 32'h0000ABCD, 4'hF, 3'b001);
        check("t6_in_resp", 64'(bvalid), 64'(1));
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_async_b", 64'(bvalid), 64'(0));
        check("t6_async_regs", 64'(regs == '0), 64'(1));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check("t6_ready_before_edge", 64'({awready, wready, arready}), 64'(0));
        tick();
        check("t6_ready_after_edge", 64'({awready, wready, arready}), 64'(3'b111));

        for (int i = 0; i < 20 && (exp_b.size() + exp_r.size()) != 0; i++) tick();
        check("queues_drained", 64'(exp_b.size() + exp_r.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_reg_slave.md
Name: axi4_lite_reg_slave

Overview:
AXI4-lite responder (subordinate) terminating one AXI4-lite link into a bank of REG_COUNT read/write registers of width 8*N.
- Sits at the slave end of an AXI4-lite link; the interconnect or bus master drives it.
- Exposes the register contents and per-register write strobes to local logic.
- Read and write channels are serviced independently. AW and W may arrive in either order or in the same cycle.

Parameters:
A, 32, address width in bits
N, 4, data width in bytes (data = 8*N bits)
REG_COUNT, 16, number of registers (power of 2, >= 2)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
awaddr  in  A  write address
awprot  in  3  write protection
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  8*N  write data
wstrb  in  N  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  A  read address
arprot  in  3  read protection
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  8*N  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
regs  out  REG_COUNT*8*N  flattened register contents, reg k at [k*8N +: 8N]
wr_pulse  out  REG_COUNT  one-cycle pulse on the cycle register k is updated

Behaviour:
Reset:
- While aresetn is low: all registers = 0; awready, wready, arready, bvalid, rvalid, wr_pulse = 0; bresp, rresp, rdata = 0.
- Asserting reset mid-transaction aborts it; no partial write is committed.

Address decode:
- idx = addr[$clog2(N) +: $clog2(REG_COUNT)]; low $clog2(N) bits are ignored (unaligned addresses are truncated).
- Out of range: any addr bit at or above $clog2(N)+$clog2(REG_COUNT) is set -> response SLVERR (2'b10). Otherwise OKAY (2'b00).

Write FSM (W_IDLE, W_RESP):
- W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. Each is captured on its own valid&ready handshake.
- When both are captured (either order, or in the same cycle), transition to W_RESP on the next edge. On that edge:
  - commit the write: for each byte b with wstrb[b]=1, reg[idx] byte b <= wdata byte b;
  - pulse wr_pulse[idx] for one cycle, coincident with bvalid first asserting;
  - out-of-range writes commit nothing and raise no pulse;
  - wstrb=0 is a legal no-op: bresp OKAY, wr_pulse still pulses.
- W_RESP: bvalid=1 and bresp held stable; awready=wready=0. On bvalid&bready -> W_IDLE, clear captures; awready/wready reassert on the next cycle.
- Minimum write latency: bvalid asserts 1 cycle after the later of the AW/W handshakes.

Read FSM (R_IDLE, R_DATA):
- R_IDLE: arready=1. On arvalid&arready, capture rdata = reg[idx] (or 0 if out of range) and rresp, then -> R_DATA.
- R_DATA: rvalid=1, arready=0, rdata/rresp held stable. On rvalid&rready -> R_IDLE.
- Read latency: rvalid asserts 1 cycle after the AR handshake. Throughput: 1 read per 2 cycles.

Simultaneous read and write to the same register:
- Read returns the value before the write when the AR handshake occurs on or before the commit edge.
- The read and write FSMs never stall each other.

Protocol robustness:
- bvalid/rvalid, once asserted, stay high until their handshake.
- Outputs never depend combinationally on inputs; all outputs are registered.

Optional Feature:
AXI4_LITE_REG_SLAVE_PROT_CHECK_EN
- Defined: accesses with prot[0]=0 (unprivileged) are rejected with SLVERR.
  - Such a write commits nothing and raises no wr_pulse.
  - Such a read returns rdata=0.
  - Handshake timing is unchanged.
- Undefined: awprot/arprot are ignored and only the range check produces SLVERR.

Decomposition:
- axi4_lite_pkg gains:
  - response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the write and read FSM state enums;
  - a function computing the register index and range flag from an address, N and REG_COUNT.
- No sub-module. The write and read paths are two always_ff blocks in one module. The register bank is inline.

Test Plan:
- Write addr 0x08, wdata 0xDEADBEEF, wstrb 4'hF, AW and W in the same cycle -> bvalid next cycle, bresp 0; regs[2]=0xDEADBEEF; wr_pulse[2] high exactly 1 cycle; then read 0x08 -> rdata 0xDEADBEEF, rresp 0, rvalid 1 cycle after the AR handshake.
- W handshake 3 cycles before AW (addr 0x04, wstrb 4'b0101, data 0x11223344 onto reg 0xFFFFFFFF) -> regs[1]=0xFF22FF44; bvalid 1 cycle after the AW handshake.
- Write and read to addr 0x40 (REG_COUNT=16, N=4) -> bresp 2'b10, no wr_pulse, all regs unchanged; rresp 2'b10, rdata 0.
- bready held low 10 cycles -> bvalid and bresp stable throughout; awready/wready stay 0; a second AW is not accepted until the cycle after the B handshake.
- Read in flight with rready low while a write to the same register commits -> rdata keeps the old value; a subsequent read returns the new value.
- aresetn dropped while in W_RESP with regs[3]=0x5 -> bvalid and all regs go to 0 asynchronously; after release, awready/wready/arready are 1 on the first post-reset edge.
- With the macro defined: write with awprot=3'b000 -> SLVERR, register unchanged; write with awprot=3'b001 -> OKAY.
